// File: rtl/wb_mem_slave_pkg.sv
// Shared types, defaults and the byte-lane merge helper for the WB memory slave.
package wb_mem_pkg;

  localparam int DEPTH_DEFAULT = 256;
  localparam int AW_DEFAULT    = $clog2(DEPTH_DEFAULT);

  // One-hot encoding keeps every state decode a single flop bit.
  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    RD     = 6'b000010,
    RMW_RD = 6'b000100,
    WR     = 6'b001000,
    ACK    = 6'b010000,
    ERR    = 6'b100000
  } state_t;

  // Lanes with sel set take the new data, the rest keep the word read from memory.
  function automatic logic [31:0] byte_merge(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    merged = oldWord;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) begin
        merged[8*n +: 8] = newWord[8*n +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_mem_slave_if.sv
// Wishbone classic bus bundle between an interconnect master and the memory slave.
interface wb_mem_slave_if;

  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

endinterface

// File: rtl/wb_mem_slave.sv
// Wishbone classic slave in front of a single-port word memory on a shared
// tri-state data bus. Byte-lane writes are done as read-modify-write because
// the memory itself has no byte enables.
module wb_mem_slave
  import wb_mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clock,
  input  logic         rst,
  wb_mem_slave_if.slave wb,
  output logic [31:0]  mem_adr,
  output logic         mem_wen,
  inout  wire  [31:0]  mem_data
);

  state_t          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     datIn_q, datIn_d;
  logic [31:0]     wData_q, wData_d;
  logic [31:0]     datOut_q, datOut_d;
  logic            ack_q, err_q, memWen_q;
  logic            request;
  logic            addrErr;

  assign request = wb.wb_cyc_i && wb.wb_stb_i;
  assign addrErr = (wb.wb_adr_i[1:0] != 2'b00) ||
                   ((wb.wb_adr_i >> (AW + 2)) != 32'd0);

  // Next-state logic: decode the request in IDLE, abort reads on a dropped cycle, finish writes.
  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    datIn_d  = datIn_q;
    wData_d  = wData_q;
    datOut_d = datOut_q;
    unique case (state_q)
      IDLE: begin
        if (request) begin
          adr_d   = wb.wb_adr_i[AW+1:2];
          sel_d   = wb.wb_sel_i;
          datIn_d = wb.wb_dat_i;
          if (addrErr || (wb.wb_we_i && (wb.wb_sel_i == 4'h0))) begin
            state_d = ERR;
          end else if (!wb.wb_we_i) begin
            state_d = RD;
          end else if (wb.wb_sel_i == 4'hF) begin
            state_d = WR;
            wData_d = wb.wb_dat_i;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      RD: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          datOut_d = mem_data;
          state_d  = ACK;
        end
      end
      RMW_RD: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          wData_d = byte_merge(mem_data, datIn_q, sel_q);
          state_d = WR;
        end
      end
      WR:      state_d = ACK;
      ACK:     state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and registered outputs; strobes follow the state being entered.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      sel_q    <= '0;
      datIn_q  <= '0;
      wData_q  <= '0;
      datOut_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      memWen_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      datIn_q  <= datIn_d;
      wData_q  <= wData_d;
      datOut_q <= datOut_d;
      ack_q    <= (state_d == ACK);
      err_q    <= (state_d == ERR);
      memWen_q <= (state_d == WR);
    end
  end

  assign wb.wb_dat_o = datOut_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;

  assign mem_adr  = {{(32-AW){1'b0}}, adr_q};
  assign mem_wen  = memWen_q;
  // Only the registered write enable opens our driver, so the memory and
  // the slave never drive the bus in the same cycle.
  assign mem_data = memWen_q ? wData_q : 32'bz;

endmodule

// File: tb/tb_wb_mem_slave.sv
// Directed bench: WB slave plus a behavioural single-port memory on the shared bus.
module tb_wb_mem_slave;

  localparam int AW = wb_mem_pkg::AW_DEFAULT;

  logic        clock;
  logic        rst;
  logic [31:0] memAdr;
  logic        memWen;
  wire  [31:0] memData;
  logic [31:0] memArr [0:(1<<AW)-1];

  int checkCount = 0;
  int passCount  = 0;

  wb_mem_slave_if wbIf ();

  wb_mem_slave dut (
    .clock    (clock),
    .rst      (rst),
    .wb       (wbIf.slave),
    .mem_adr  (memAdr),
    .mem_wen  (memWen),
    .mem_data (memData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural memory: combinational read drive when not writing, cleared by reset.
  always @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < (1<<AW); i++) memArr[i] <= 32'd0;
    end else if (memWen) begin
      memArr[memAdr[AW-1:0]] <= memData;
    end
  end

  assign memData = memWen ? 32'bz : memArr[memAdr[AW-1:0]];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        expErr;
    int          expLat;
    int          expWen;
    logic [31:0] expDatO;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    end
  endtask

  // Per-cycle bus hygiene: no X/contention on the shared bus, never ack with err, index in range.
  function automatic int busFault();
    int f = 0;
    if ($isunknown(memData)) f++;
    if (wbIf.wb_ack_o && wbIf.wb_err_o) f++;
    if (memAdr[31:AW] != '0) f++;
    return f;
  endfunction

  task automatic driveIdle();
    wbIf.wb_cyc_i = 1'b0;
    wbIf.wb_stb_i = 1'b0;
    wbIf.wb_we_i  = 1'b0;
    wbIf.wb_adr_i = 32'd0;
    wbIf.wb_sel_i = 4'h0;
    wbIf.wb_dat_i = 32'd0;
  endtask

  task automatic driveReq(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    wbIf.wb_cyc_i = 1'b1;
    wbIf.wb_stb_i = 1'b1;
    wbIf.wb_we_i  = we;
    wbIf.wb_adr_i = adr;
    wbIf.wb_sel_i = sel;
    wbIf.wb_dat_i = dat;
  endtask

  // Issue one transfer, count cycles to ack/err (request cycle is 0), bounded to 8 cycles.
  task automatic applyStimulus(input vec_t v, output int lat, output logic gotErr,
                               output int wens, output logic [31:0] datO, output int bad);
    lat = -1; gotErr = 1'b0; wens = 0; bad = 0; datO = 32'hxxxxxxxx;
    @(negedge clock);
    driveReq(v.we, v.adr, v.sel, v.dat);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      bad += busFault();
      if (memWen) wens++;
      if (wbIf.wb_ack_o || wbIf.wb_err_o) begin
        lat    = k;
        gotErr = wbIf.wb_err_o;
        datO   = wbIf.wb_dat_o;
        break;
      end
    end
    driveIdle();
  endtask

  // Start a transfer, drop cyc one cycle later, then watch for any completion or write.
  task automatic abortSequence(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, output int dones, output int wens, output int bad);
    dones = 0; wens = 0; bad = 0;
    @(negedge clock);
    driveReq(we, adr, sel, dat);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) driveIdle();
      bad += busFault();
      if (memWen) wens++;
      if (wbIf.wb_ack_o || wbIf.wb_err_o) dones++;
    end
  endtask

  int          lat, wens, bad, dones;
  logic        gotErr;
  logic [31:0] datO;

  initial begin
    vecs[0]  = '{1'b1, 32'h10,  4'hF,    32'hDEADBEEF, 1'b0, 2, 1, 32'h00000000};
    vecs[1]  = '{1'b0, 32'h10,  4'hF,    32'h0,        1'b0, 2, 0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h10,  4'b0011, 32'h00001234, 1'b0, 3, 1, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'h10,  4'hF,    32'h0,        1'b0, 2, 0, 32'hDEAD1234};
    vecs[4]  = '{1'b1, 32'h400, 4'hF,    32'h55555555, 1'b1, 1, 0, 32'hDEAD1234};
    vecs[5]  = '{1'b0, 32'h11,  4'hF,    32'h0,        1'b1, 1, 0, 32'hDEAD1234};
    vecs[6]  = '{1'b1, 32'h14,  4'h0,    32'hFFFFFFFF, 1'b1, 1, 0, 32'hDEAD1234};
    vecs[7]  = '{1'b0, 32'h10,  4'hF,    32'h0,        1'b0, 2, 0, 32'hDEAD1234};
    vecs[8]  = '{1'b1, 32'h3FC, 4'b1000, 32'hAB000000, 1'b0, 3, 1, 32'hDEAD1234};
    vecs[9]  = '{1'b0, 32'h3FC, 4'hF,    32'h0,        1'b0, 2, 0, 32'hAB000000};
    vecs[10] = '{1'b1, 32'h20,  4'b0101, 32'h11223344, 1'b0, 3, 1, 32'hAB000000};
    vecs[11] = '{1'b0, 32'h20,  4'hF,    32'h0,        1'b0, 2, 0, 32'h00220044};

    driveIdle();
    rst = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("reset ack",  {31'd0, wbIf.wb_ack_o}, 32'd0);
    checkOutput("reset err",  {31'd0, wbIf.wb_err_o}, 32'd0);
    checkOutput("reset datO", wbIf.wb_dat_o, 32'd0);
    checkOutput("reset wen",  {31'd0, memWen}, 32'd0);
    checkOutput("reset adr",  memAdr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], lat, gotErr, wens, datO, bad);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d err", i), {31'd0, gotErr}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("v%0d wen cycles", i), 32'(wens), 32'(vecs[i].expWen));
      checkOutput($sformatf("v%0d dat_o", i), datO, vecs[i].expDatO);
      checkOutput($sformatf("v%0d bus faults", i), 32'(bad), 32'd0);
    end

    abortSequence(1'b0, 32'h10, 4'hF, 32'h0, dones, wens, bad);
    checkOutput("abort rd completions", 32'(dones), 32'd0);
    checkOutput("abort rd wen", 32'(wens), 32'd0);
    checkOutput("abort rd datO held", wbIf.wb_dat_o, 32'h00220044);
    checkOutput("abort rd faults", 32'(bad), 32'd0);

    abortSequence(1'b1, 32'h10, 4'b0011, 32'h0000FFFF, dones, wens, bad);
    checkOutput("abort rmw completions", 32'(dones), 32'd0);
    checkOutput("abort rmw wen", 32'(wens), 32'd0);
    checkOutput("abort rmw faults", 32'(bad), 32'd0);
    applyStimulus('{1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 2, 0, 32'hDEAD1234}, lat, gotErr, wens, datO, bad);
    checkOutput("after abort latency", 32'(lat), 32'd2);
    checkOutput("after abort mem[4]", datO, 32'hDEAD1234);

    @(negedge clock);
    driveReq(1'b0, 32'h10, 4'hF, 32'h0);
    @(negedge clock);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst ack",  {31'd0, wbIf.wb_ack_o}, 32'd0);
    checkOutput("midrst err",  {31'd0, wbIf.wb_err_o}, 32'd0);
    checkOutput("midrst datO", wbIf.wb_dat_o, 32'd0);
    checkOutput("midrst wen",  {31'd0, memWen}, 32'd0);
    checkOutput("midrst adr",  memAdr, 32'd0);
    checkOutput("midrst bus",  memData, 32'd0);
    driveIdle();
    #1 rst = 1'b0;
    applyStimulus('{1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 2, 0, 32'h0}, lat, gotErr, wens, datO, bad);
    checkOutput("post reset latency", 32'(lat), 32'd2);
    checkOutput("post reset read", datO, 32'd0);
    checkOutput("post reset faults", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
